ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
PS/2 device-to-host receiver with a byte FIFO. It sits directly upstream of the keyboard make/break FSM and display logic, and feeds them through the ready / nextdata_n / data handshake.
- Synchronises the asynchronous ps2_clk / ps2_data lines into clk.
- Deframes 11-bit frames and checks start, parity and stop bits.
- Buffers good scan-code bytes until the consumer pops them.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (default 8).
- TIMEOUT_CYC, 5000, clk cycles without a ps2_clk falling edge mid-frame before the frame is abandoned.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock line; asynchronous to clk.
- ps2_data  in  1  raw PS/2 data line; asynchronous to clk.
- nextdata_n  in  1  active-low pop request from the consumer.
- data  out  8  FIFO head byte; valid only while ready=1.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky flag: a good frame was dropped because the FIFO was full.
- sampling  out  1  one-cycle pulse on each detected ps2_clk falling edge.
- frame_err  out  1  one-cycle pulse when a frame is rejected or abandoned.

Behaviour:
- Reset: clock synchroniser, bit counter, shift register, FIFO pointers and timeout counter are cleared.
  - ready=0, overflow=0, sampling=0, frame_err=0, data=8'h00.
  - Reset mid-frame discards the partial frame with no frame_err pulse.
- Synchroniser: 3-flop chain on ps2_clk. A falling edge is stage2=0 and stage3=1.
  - On that cycle: sampling=1, and ps2_data (2-flop synchronised) is shifted into an 11-bit register, LSB first.
  - The 4-bit bit counter increments.
- Frame check, performed on the 11th sample:
  - Start bit b0 must be 0.
  - Stop bit b10 must be 1.
  - ^b[9:1] must be 1 (odd parity over data plus parity bit).
  - Pass: b[8:1] is pushed to the FIFO.
  - Fail: byte discarded; frame_err=1 on the following cycle.
  - In both cases the bit counter returns to 0.
- Latency: ready (and the new data, if the FIFO was empty) is visible 1 clk after the cycle in which the 11th sampling pulse is asserted.
- Timeout:
  - A counter runs only while 0 < bit counter < 11, and clears on every sampling pulse.
  - On reaching TIMEOUT_CYC: bit counter := 0, frame_err pulses, no push.
- FIFO:
  - data is driven from storage at rd_ptr (registered storage, combinational read).
  - Pointers are DEPTH_LOG2+1 bits; full/empty is determined by MSB compare; pointers wrap modulo 2**(DEPTH_LOG2+1).
  - Pop: on each clk where nextdata_n=0 and ready=1, rd_ptr advances.
    - One pop per low cycle; the consumer pulses nextdata_n for one cycle per byte.
    - nextdata_n=0 while empty is ignored.
  - Push while full with no pop: byte dropped, overflow:=1.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: pop ignored, push stored; ready=1 on the next cycle.
  - overflow clears on the next accepted pop, or on rst.
- Ordering: bytes leave in exact arrival order (e.g. 0xF0 before the following break code).

Decomposition:
- Shared package ps2_pkg:
  - PS2_FRAME_BITS=11.
  - Bit-position constants START_BIT=0, PARITY_BIT=9, STOP_BIT=10.
  - Default TIMEOUT_CYC.
  - Scan-code constants such as BREAK_PREFIX=8'hF0, reused by the downstream FSM.
- One sub-module: ps2_byte_fifo.
  - Parameter DEPTH_LOG2.
  - Ports: push/din/pop/dout/empty/full.
  - Holds storage and pointers; the top level holds the synchroniser, deframer, timeout and flag logic.

Test Plan:
- Single good frame, byte 0x1C (parity bit 0): sampling pulses 11 times; ready=1 with data=0x1C; one-cycle nextdata_n=0 gives ready=0 on the next clk.
- Frames 0xF0, 0x1C sent with no pops: data=0xF0; after pop data=0x1C; after a second pop ready=0. overflow stays 0 and frame_err never pulses.
- Frame 0x1C with parity flipped to 1: frame_err pulses exactly once; ready stays 0. A following good frame 0x32 yields data=0x32.
- Nine good frames (0x01..0x09) with no pops: ready=1 and overflow=1 after the 9th. Eight pops return 0x01..0x08 in order; overflow clears after the first pop.
- Five bits of a frame, then ps2_clk held high for TIMEOUT_CYC+2 clks: exactly one frame_err pulse. A subsequent full frame 0x32 is received correctly.
- rst asserted asynchronously after 6 bits with 2 bytes queued: all outputs go to reset values immediately. After release, a fresh frame 0x1C is received with data=0x1C.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, frame-status type and frame checker used by the
// receiver and the downstream make/break decoding logic.
package ps2_pkg;

    localparam int PS2_FRAME_BITS      = 11;
    localparam int START_BIT           = 0;
    localparam int PARITY_BIT          = 9;
    localparam int STOP_BIT            = 10;
    localparam int DEFAULT_TIMEOUT_CYC = 5000;

    localparam logic [7:0] BREAK_PREFIX  = 8'hF0;
    localparam logic [7:0] EXTEND_PREFIX = 8'hE0;

    typedef enum logic [1:0] {
        FRAME_OK,
        FRAME_BAD_START,
        FRAME_BAD_PARITY,
        FRAME_BAD_STOP
    } frame_status_e;

    // Parity is odd over the eight data bits plus the parity bit.
    function automatic frame_status_e check_frame(input logic [PS2_FRAME_BITS-1:0] f);
        frame_status_e status;
        status = FRAME_OK;
        if (f[START_BIT]) begin
            status = FRAME_BAD_START;
        end else if (!(^f[PARITY_BIT:START_BIT+1])) begin
            status = FRAME_BAD_PARITY;
        end else if (!f[STOP_BIT]) begin
            status = FRAME_BAD_STOP;
        end
        return status;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO with registered storage and combinational head read; pointers
// carry one extra wrap bit so full and empty are told apart by the MSB.
module ps2_byte_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]          mem_q [DEPTH];
    logic [7:0]          mem_d [DEPTH];
    logic                do_push;
    logic                do_pop;

    // A push into a full FIFO is still accepted when a pop frees the head slot.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        dout     = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the PS/2 lines, deframes and
// checks 11-bit frames, and queues good scan-code bytes for the consumer.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2  = 3,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       sampling,
    output logic       frame_err
);

    localparam int                TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]        LAST_IDX = 4'(PS2_FRAME_BITS - 1);

    logic [2:0]                clk_sync_q, clk_sync_d;
    logic [1:0]                data_sync_q, data_sync_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
    logic                      overflow_q, overflow_d;
    logic                      frame_err_q, frame_err_d;

    logic [PS2_FRAME_BITS-1:0] frame;
    frame_status_e             status;
    logic                      fall;
    logic                      last_bit;
    logic                      push;
    logic                      pop;
    logic                      fifo_empty;
    logic                      fifo_full;

    // Falling edge seen as stage2 low while stage3 still high; the frame
    // view includes the bit being shifted in this cycle.
    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        fall        = !clk_sync_q[1] && clk_sync_q[2];
        frame       = {data_sync_q[1], shift_q[PS2_FRAME_BITS-1:1]};
        status      = check_frame(frame);
        last_bit    = fall && (bit_cnt_q == LAST_IDX);
        push        = last_bit && (status == FRAME_OK);
        pop         = !nextdata_n && !fifo_empty;

        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = to_cnt_q;
        frame_err_d = 1'b0;
        if (fall) begin
            shift_d     = frame;
            bit_cnt_d   = last_bit ? 4'd0 : bit_cnt_q + 4'd1;
            to_cnt_d    = '0;
            frame_err_d = last_bit && (status != FRAME_OK);
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TO_LAST) begin
                bit_cnt_d   = 4'd0;
                to_cnt_d    = '0;
                frame_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end

        overflow_d = overflow_q;
        if (pop) begin
            overflow_d = 1'b0;
        end else if (push && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    ps2_byte_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (frame[PARITY_BIT-1:START_BIT+1]),
        .pop  (pop),
        .dout (data),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign ready     = !fifo_empty;
    assign overflow  = overflow_q;
    assign sampling  = fall;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised self-checking bench for ps2_rx_fifo against a queue-based
// model of the receiver's frame rules and FIFO behaviour.
module tb_ps2_rx_fifo;

    localparam int TB_TIMEOUT = 300;
    localparam int H          = 16;
    localparam int DEPTH      = 8;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       sampling;
    logic       frame_err;

    int         n_checks;
    int         n_fail;
    int         samp_cnt;
    int         err_cnt;
    logic [7:0] exp_q[$];
    logic       exp_ovf;

    ps2_rx_fifo #(
        .DEPTH_LOG2 (3),
        .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .sampling  (sampling),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (sampling)  samp_cnt++;
            if (frame_err) err_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string where);
        checkOutput({where, " ready"}, ready, exp_q.size() != 0);
        if (exp_q.size() != 0) checkOutput({where, " data"}, data, exp_q[0]);
        checkOutput({where, " overflow"}, overflow, exp_ovf);
    endtask

    // kind: 0 good, 1 parity flipped, 2 bad start, 3 bad stop.
    // overlap_pop pulses nextdata_n so the pop lands on the same clk as the push.
    task automatic applyStimulus(input logic [7:0] b, input int kind, input int nbits,
                                 input bit overlap_pop);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = b;
        f[9]    = ~^b;
        f[10]   = 1'b1;
        if (kind == 1) f[9]  = ~f[9];
        if (kind == 2) f[0]  = 1'b1;
        if (kind == 3) f[10] = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_clk(H / 2);
            ps2_clk = 1'b0;
            if (overlap_pop && i == nbits - 1) begin
                wait_clk(2);
                nextdata_n = 1'b0;
                wait_clk(1);
                nextdata_n = 1'b1;
                wait_clk(H - 3);
            end else begin
                wait_clk(H);
            end
            ps2_clk = 1'b1;
            wait_clk(H / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_and_check(input logic [7:0] b, input int kind, input bit overlap_pop);
        int s0;
        int e0;
        s0 = samp_cnt;
        e0 = err_cnt;
        applyStimulus(b, kind, 11, overlap_pop);
        wait_clk(4);
        if (overlap_pop && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            exp_ovf = 1'b0;
        end
        if (kind == 0) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else                      exp_ovf = 1'b1;
        end
        checkOutput("sampling count", samp_cnt - s0, 11);
        checkOutput("frame_err count", err_cnt - e0, (kind != 0) ? 1 : 0);
        check_state("frame");
    endtask

    task automatic pop_one();
        if (exp_q.size() != 0) checkOutput("pop head", data, exp_q[0]);
        nextdata_n = 1'b0;
        wait_clk(1);
        nextdata_n = 1'b1;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            exp_ovf = 1'b0;
        end
        wait_clk(1);
        check_state("pop");
    endtask

    task automatic drain();
        while (exp_q.size() != 0) pop_one();
    endtask

    initial begin
        int s0;
        int e0;
        n_checks   = 0;
        n_fail     = 0;
        samp_cnt   = 0;
        err_cnt    = 0;
        exp_ovf    = 1'b0;
        rst        = 1'b1;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        wait_clk(3);
        checkOutput("reset ready", ready, 0);
        checkOutput("reset data", data, 8'h00);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset sampling", sampling, 0);
        checkOutput("reset frame_err", frame_err, 0);
        rst = 1'b0;
        wait_clk(4);

        $display("[TB] single frame 0x1C");
        send_and_check(8'h1C, 0, 1'b0);
        pop_one();

        $display("[TB] break sequence ordering");
        send_and_check(8'hF0, 0, 1'b0);
        send_and_check(8'h1C, 0, 1'b0);
        pop_one();
        pop_one();

        $display("[TB] parity error then good frame");
        send_and_check(8'h1C, 1, 1'b0);
        send_and_check(8'h32, 0, 1'b0);
        send_and_check(8'h55, 2, 1'b0);
        send_and_check(8'hAA, 3, 1'b0);
        drain();
        pop_one();

        $display("[TB] overflow with nine frames");
        for (int i = 1; i <= 9; i++) send_and_check(8'(i), 0, 1'b0);
        drain();

        $display("[TB] push and pop on the same clk");
        send_and_check(8'h77, 0, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) send_and_check(8'(8'h40 + i), 0, 1'b0);
        send_and_check(8'h99, 0, 1'b1);
        send_and_check(8'h5A, 0, 1'b0);
        drain();

        $display("[TB] timeout mid-frame");
        s0 = samp_cnt;
        e0 = err_cnt;
        applyStimulus(8'h1C, 0, 5, 1'b0);
        wait_clk(TB_TIMEOUT + 12);
        checkOutput("timeout sampling", samp_cnt - s0, 5);
        checkOutput("timeout frame_err", err_cnt - e0, 1);
        check_state("timeout");
        send_and_check(8'h32, 0, 1'b0);
        drain();

        $display("[TB] randomised frames and pops");
        for (int n = 0; n < 30; n++) begin
            logic [7:0] b;
            int         kind;
            int         npop;
            b    = 8'($urandom);
            kind = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_and_check(b, kind, ($urandom_range(0, 5) == 0));
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) pop_one();
        end
        drain();

        $display("[TB] asynchronous reset mid-frame");
        send_and_check(8'h11, 0, 1'b0);
        send_and_check(8'h22, 0, 1'b0);
        applyStimulus(8'h33, 0, 6, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async reset ready", ready, 0);
        checkOutput("async reset data", data, 8'h00);
        checkOutput("async reset overflow", overflow, 0);
        checkOutput("async reset sampling", sampling, 0);
        checkOutput("async reset frame_err", frame_err, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        send_and_check(8'h1C, 0, 1'b0);
        pop_one();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
